card_sprite_ctrl: RTL

Sequences the 512x3 card-image RAM (16x32-pixel card sprite, one synchronous read port and one synchronous write port, 1-cycle read latency) for the 256x240 VGA display. During active video it maps the current pixel onto up to NUM_SLOTS on-screen card placements and drives the RAM read port. It arbitrates game-logic image writes into blanking time only, using a req/ack handshake. It sits between the VGA timing generator and the colour mux.

---
 rtl/card_pkg.sv | 27 ++
 rtl/card_sprite_ctrl_if.sv | 34 +++
 rtl/card_slot_hit.sv | 35 +++
 rtl/card_sprite_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// card_pkg : shared card geometry, colour constants and loader FSM state type
// Revision : 1.0
// -----------------------------------------------------------------------------
package card_pkg;

  localparam int CARD_W_LOG2 = 4;
  localparam int CARD_W      = 1 << CARD_W_LOG2;
  localparam int CARD_H_LOG2 = 5;
  localparam int CARD_H      = 32;
  localparam int ADDR_W      = CARD_W_LOG2 + CARD_H_LOG2;
  localparam int COLOR_W     = 3;

  localparam logic [COLOR_W-1:0] TRANSP = 3'b000;

  localparam int SCREEN_W = 256;
  localparam int SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/card_sprite_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// card_sprite_ctrl_if : loader req/ack handshake and card-image RAM port bundle
// Revision : 1.0
// -----------------------------------------------------------------------------
interface card_sprite_ctrl_if;
  import card_pkg::*;

  logic               ld_req;
  logic [ADDR_W-1:0]  ld_addr;
  logic [COLOR_W-1:0] ld_data;
  logic               ld_ack;

  logic               mem_WE;
  logic               mem_RE;
  logic [ADDR_W-1:0]  mem_wAddr;
  logic [ADDR_W-1:0]  mem_rAddr;
  logic [COLOR_W-1:0] mem_dataIn;
  logic [COLOR_W-1:0] mem_dataOut;

  // The sprite controller is the slave of this bundle.
  modport slave (
    input  ld_req, ld_addr, ld_data, mem_dataOut,
    output ld_ack, mem_WE, mem_RE, mem_wAddr, mem_rAddr, mem_dataIn
  );

  // Loader plus RAM environment.
  modport master (
    output ld_req, ld_addr, ld_data, mem_dataOut,
    input  ld_ack, mem_WE, mem_RE, mem_wAddr, mem_rAddr, mem_dataIn
  );

endinterface
`default_nettype wire

// File: rtl/card_slot_hit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// card_slot_hit : combinational hit test of one card placement, card-relative offset
// Revision : 1.0
// -----------------------------------------------------------------------------
module card_slot_hit
  import card_pkg::*;
(
  input  logic                   pix_x_dummy_unused,
  input  logic [7:0]             pix_x,
  input  logic [7:0]             pix_y,
  input  logic                   pix_active,
  input  logic [7:0]             slot_x,
  input  logic [7:0]             slot_y,
  input  logic                   slot_en,
  output logic                   hit,
  output logic [CARD_W_LOG2-1:0] dx,
  output logic [CARD_H_LOG2-1:0] dy
);

  logic [8:0] w_dx;
  logic [8:0] w_dy;

  // Bit 8 is the borrow: pixel left of / above the card, so no wrap-around.
  always_comb begin
    w_dx = {1'b0, pix_x} - {1'b0, slot_x};
    w_dy = {1'b0, pix_y} - {1'b0, slot_y};
    hit  = slot_en && pix_active && !w_dx[8] && !w_dy[8] &&
           (w_dx < 9'(CARD_W)) && (w_dy < 9'(CARD_H));
    dx   = w_dx[CARD_W_LOG2-1:0];
    dy   = w_dy[CARD_H_LOG2-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/card_sprite_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// card_sprite_ctrl : card sprite read pipeline and blanking-time image loader
// Revision : 1.0
// -----------------------------------------------------------------------------
module card_sprite_ctrl
  import card_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             pix_x,
  input  logic [7:0]             pix_y,
  input  logic                   pix_active,
  input  logic [NUM_SLOTS*8-1:0] slot_x,
  input  logic [NUM_SLOTS*8-1:0] slot_y,
  input  logic [NUM_SLOTS-1:0]   slot_en,
  card_sprite_ctrl_if.slave      bus,
  output logic                   px_valid,
  output logic                   px_hit,
  output logic [COLOR_W-1:0]     px_color
);

  logic [NUM_SLOTS-1:0]   w_hit;
  logic [CARD_W_LOG2-1:0] w_dx [NUM_SLOTS];
  logic [CARD_H_LOG2-1:0] w_dy [NUM_SLOTS];
  logic                   w_any;
  logic [ADDR_W-1:0]      w_addr;

  logic                   r_s1_hit;
  logic                   r_s1_valid;
  logic [ADDR_W-1:0]      r_raddr;
  logic                   r_s2_hit;
  logic                   r_s2_valid;

  ld_state_t              r_state;
  ld_state_t              w_next;
  logic                   w_we;
  logic                   w_ack;
  logic                   w_capture;
  logic                   r_we;
  logic                   r_ack;
  logic [ADDR_W-1:0]      r_waddr;
  logic [COLOR_W-1:0]     r_wdata;

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      card_slot_hit u_hit (
        .pix_x_dummy_unused (1'b0),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_active (pix_active),
        .slot_x     (slot_x[8*g +: 8]),
        .slot_y     (slot_y[8*g +: 8]),
        .slot_en    (slot_en[g]),
        .hit        (w_hit[g]),
        .dx         (w_dx[g]),
        .dy         (w_dy[g])
      );
    end
  endgenerate

  // Scan from the top so the lowest-index hitting slot is written last and wins.
  always_comb begin
    w_any  = 1'b0;
    w_addr = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any  = 1'b1;
        w_addr = {w_dy[i], w_dx[i]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_hit   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_raddr    <= '0;
      r_s2_hit   <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_hit   <= w_any;
      r_s1_valid <= pix_active;
      if (w_any) begin
        r_raddr <= w_addr;
      end
      r_s2_hit   <= r_s1_hit;
      r_s2_valid <= r_s1_valid;
    end
  end

  assign bus.mem_rAddr = r_raddr;
  assign bus.mem_RE    = r_s1_hit;

  // The RAM output register is the second pipeline stage, so the colour is
  // qualified directly from mem_dataOut alongside the registered hit flag.
  assign px_valid = r_s2_valid;
  assign px_hit   = r_s2_hit && (bus.mem_dataOut != TRANSP);
  assign px_color = px_hit ? bus.mem_dataOut : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.ld_req && !pix_active) w_next = WRITE;
      WRITE:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_we      = (w_next == WRITE);
    w_ack     = (w_next == ACK);
    w_capture = (r_state == IDLE) && (w_next == WRITE);
  end

  // Outputs are registered off the next state so they align with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we  <= w_we;
      r_ack <= w_ack;
      if (w_capture) begin
        r_waddr <= bus.ld_addr;
        r_wdata <= bus.ld_data;
      end
    end
  end

  assign bus.mem_WE     = r_we;
  assign bus.mem_wAddr  = r_waddr;
  assign bus.mem_dataIn = r_wdata;
  assign bus.ld_ack     = r_ack;

endmodule
`default_nettype wire
